regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have the ports v0, input, 1 bit; a0, input, 3 bits; d0, input, 19 bits: requester 0 (ALU writeback) valid, destination register and data.
REQ-004 The block SHALL have the port rdy0, output, 1 bit: requester 0 accepted this cycle; transfer occurs when v0 and rdy0 are both high.
REQ-005 The block SHALL have the ports v1, a1, d1 and rdy1 with the same directions, widths and meanings as REQ-003/REQ-004: requester 1 (load writeback).
REQ-006 The block SHALL have the port wE3, output, 1 bit: register-file write enable.
REQ-007 The block SHALL have the port A3, output, 3 bits: register-file write address.
REQ-008 The block SHALL have the port wD3, output, 19 bits: register-file write data.
REQ-009 The block SHALL have the port stall_cnt, output, 8 bits: saturating count of lost-arbitration cycles.
REQ-010 The block SHALL have the port last_gnt, output, 1 bit: index of the most recently granted requester.

Function
REQ-011 rdy0 and rdy1 SHALL be combinational from the current inputs and state; at most one SHALL be high per cycle.
REQ-012 Grant SHALL go only to a valid requester; with exactly one valid requester, that requester SHALL be granted in the same cycle.
REQ-013 With both valid, priority SHALL go to requester 0, except when the aging counter is 4 or more, in which case priority SHALL go to requester 1.
REQ-014 Aging counter (3 bits): SHALL increment, saturating at 7, each cycle v1 is high and rdy1 is low; SHALL clear on a requester 1 grant or whenever v1 is low.
REQ-015 An accepted transfer SHALL appear on wE3/A3/wD3 exactly one cycle later, with wE3 high for one cycle only; latency is 1.
REQ-016 An accepted transfer with address 0 SHALL complete its handshake but SHALL drive wE3 low the next cycle (R0 hardwired zero); A3/wD3 still update.
REQ-017 A3 and wD3 SHALL hold their last values when no transfer is accepted.
REQ-018 On same-address conflict, the loser SHALL write in a later cycle, after the winner, so its value is final.
REQ-019 stall_cnt SHALL increment by 1 each cycle in which at least one requester is valid and not granted, saturating at 255 with no wrap.
REQ-020 last_gnt SHALL update on each grant, from a0 or a1 side, and hold otherwise.
REQ-021 Requester inputs SHALL be held stable by the requester until accepted; the block SHALL NOT buffer more than the single output stage.

Reset
REQ-022 Asserting rst SHALL immediately force wE3=0, A3=0, wD3=0, stall_cnt=0, last_gnt=1 and the aging counter to 0, independent of clk.
REQ-023 While rst is high, rdy0 and rdy1 SHALL be 0; a transfer in the output stage when rst asserts SHALL be discarded (no write).
REQ-024 After rst deasserts, grants SHALL resume on the first rising edge of clk.

Configuration
REQ-025 With the macro WB_ROUND_ROBIN_EN defined, the both-valid case SHALL grant the requester other than last_gnt, and the aging counter and the aging rule of REQ-013 SHALL be absent.
REQ-026 Without WB_ROUND_ROBIN_EN, the fixed-priority-plus-aging rule of REQ-013/REQ-014 SHALL apply.
REQ-027 The interface SHALL be identical in both builds.

Verification
REQ-028 The bench SHALL cover: only v0, a0=3, d0=0x1234 -> rdy0=1 same cycle; next cycle wE3=1, A3=3, wD3=0x1234, then wE3=0.
REQ-029 The bench SHALL cover: v0 and v1 held high continuously (default build) -> grants 0,0,0,0,1 repeating; stall_cnt increments every cycle.
REQ-030 The bench SHALL cover: WB_ROUND_ROBIN_EN build, both valid continuously, after reset -> grants alternate 0,1,0,1.
REQ-031 The bench SHALL cover: v1, a1=0, d1=0x7FFFF -> rdy1=1; next cycle wE3=0, A3=0.
REQ-032 The bench SHALL cover: both valid, a0=a1=5, d0=1, d1=2 -> writes in order A3=5/1 then A3=5/2.
REQ-033 The bench SHALL cover: rst pulsed mid-cycle with a write pending in the output stage -> wE3=0 immediately, stall_cnt=0, no write issued; 300 stall cycles -> stall_cnt=255.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Two-requester writeback arbiter in front of a single register-file write
// port. Requester 0 is the ALU writeback, requester 1 the load writeback.
// Each requester offers {valid, address, data} and holds it until rdyN is
// seen high. The winner is registered into a one-deep output stage, so a
// transfer accepted on edge N appears on wE3/A3/wD3 after edge N and is
// visible for exactly one cycle.
//
// Register 0 is hardwired to zero: writes to address 0 still complete
// their handshake and update A3/wD3, but wE3 stays low.
//
// Arbitration when both requesters are valid:
//   default build            : requester 0 wins, unless requester 1 has
//                              waited 4 or more consecutive cycles (aging).
//   WB_ROUND_ROBIN_EN defined: the requester other than last_gnt wins; the
//                              aging counter does not exist in this build.
//
// Same-address conflicts resolve naturally: the loser is still waiting
// when the winner is written, so its value lands later and is final.
//
// stall_cnt counts, saturating at 255, every cycle in which some valid
// requester was not granted.
//
// Reset is asynchronous and active high. While rst is high both rdy
// outputs are low, and anything in the output stage is discarded.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   // requester 0: ALU writeback
   input  logic        v0,
   input  logic [2:0]  a0,
   input  logic [18:0] d0,
   output logic        rdy0,
   // requester 1: load writeback
   input  logic        v1,
   input  logic [2:0]  a1,
   input  logic [18:0] d1,
   output logic        rdy1,
   // register-file write port
   output logic        wE3,
   output logic [2:0]  A3,
   output logic [18:0] wD3,
   // status
   output logic [7:0]  stall_cnt,
   output logic        last_gnt
);

   localparam logic [2:0] ZERO_REG  = 3'd0;
   localparam logic [7:0] STALL_MAX = 8'hFF;

`ifndef WB_ROUND_ROBIN_EN
   localparam logic [2:0] AGE_MAX    = 3'd7;
   localparam logic [2:0] AGE_THRESH = 3'd4;

   // Consecutive cycles requester 1 has been valid without a grant.
   logic [2:0] age;
`endif

   logic gnt0;
   logic gnt1;
   logic any_gnt;
   logic lost;

   // Grant decision: combinational from current requests and state.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise any path that skips an assignment infers a latch.
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (v0 && v1) begin
`ifdef WB_ROUND_ROBIN_EN
            // Alternate: serve whichever side did not win last time.
            if (last_gnt) gnt0 = 1'b1;
            else          gnt1 = 1'b1;
`else
            // Fixed priority to the ALU, overridden once loads have aged.
            if (age >= AGE_THRESH) gnt1 = 1'b1;
            else                   gnt0 = 1'b1;
`endif
         end else if (v0) begin
            gnt0 = 1'b1;
         end else if (v1) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign rdy0    = gnt0;
   assign rdy1    = gnt1;
   assign any_gnt = gnt0 | gnt1;

   // A cycle is a stall when some valid requester was turned away.
   assign lost = (v0 && !gnt0) || (v1 && !gnt1);

`ifndef WB_ROUND_ROBIN_EN
   // Aging counter: grows while requester 1 waits, clears when it is
   // served or stops requesting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age <= 3'd0;
      end else if (!v1 || gnt1) begin
         age <= 3'd0;
      end else if (age != AGE_MAX) begin
         age <= age + 3'd1;
      end
   end
`endif

   // Output stage: register the accepted transfer for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: only a few flops here, so every bit is reset; reset also
         // drops a pending write because wE3 is cleared asynchronously.
         wE3 <= 1'b0;
         A3  <= 3'd0;
         wD3 <= 19'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of statement order.
         wE3 <= 1'b0;
         if (gnt0) begin
            wE3 <= (a0 != ZERO_REG);
            A3  <= a0;
            wD3 <= d0;
         end else if (gnt1) begin
            wE3 <= (a1 != ZERO_REG);
            A3  <= a1;
            wD3 <= d1;
         end
      end
   end

   // Remember which side won most recently; hold when nobody is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt <= 1'b1;
      end else if (any_gnt) begin
         last_gnt <= gnt1;
      end
   end

   // Saturating count of lost-arbitration cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 8'd0;
      end else if (lost && (stall_cnt != STALL_MAX)) begin
         stall_cnt <= stall_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed bench for regfile_wb_arbiter. Inputs change on the falling edge,
// rdy outputs are checked shortly after, registered outputs are checked 1
// time unit after the rising edge. Expected grant pattern for the
// continuous-contention step follows WB_ROUND_ROBIN_EN when defined.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        v0, v1;
   logic [2:0]  a0, a1;
   logic [18:0] d0, d1;
   logic        rdy0, rdy1;
   logic        wE3;
   logic [2:0]  A3;
   logic [18:0] wD3;
   logic [7:0]  stall_cnt;
   logic        last_gnt;

   int n_assert = 0;
   int n_fail   = 0;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .v0        (v0),
      .a0        (a0),
      .d0        (d0),
      .rdy0      (rdy0),
      .v1        (v1),
      .a1        (a1),
      .d1        (d1),
      .rdy1      (rdy1),
      .wE3       (wE3),
      .A3        (A3),
      .wD3       (wD3),
      .stall_cnt (stall_cnt),
      .last_gnt  (last_gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic after_rise();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_g1;
      logic [7:0] exp_stall;

      rst = 1'b1;
      v0 = 1'b0; a0 = 3'd0; d0 = 19'd0;
      v1 = 1'b0; a1 = 3'd0; d1 = 19'd0;
      #2;

      // Reset state.
      check("rst_wE3",      wE3,       0);
      check("rst_A3",       A3,        0);
      check("rst_wD3",      wD3,       0);
      check("rst_stall",    stall_cnt, 0);
      check("rst_last_gnt", last_gnt,  1);
      v0 = 1'b1; v1 = 1'b1;
      #1;
      check("rst_rdy0_low", rdy0, 0);
      check("rst_rdy1_low", rdy1, 0);
      v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Single requester 0: a0=3, d0=0x1234.
      @(negedge clk);
      v0 = 1'b1; a0 = 3'd3; d0 = 19'h01234;
      #1;
      check("s0_rdy0", rdy0, 1);
      check("s0_rdy1", rdy1, 0);
      after_rise();
      check("s0_wE3",      wE3,       1);
      check("s0_A3",       A3,        3);
      check("s0_wD3",      wD3,       32'h1234);
      check("s0_last_gnt", last_gnt,  0);
      check("s0_stall",    stall_cnt, 0);
      v0 = 1'b0;
      after_rise();
      check("s0_wE3_drop", wE3, 0);
      check("s0_A3_hold",  A3,  3);
      check("s0_wD3_hold", wD3, 32'h1234);

      // Single requester 1 to R0: handshake completes, no write.
      @(negedge clk);
      v1 = 1'b1; a1 = 3'd0; d1 = 19'h7FFFF;
      #1;
      check("r0_rdy1", rdy1, 1);
      check("r0_rdy0", rdy0, 0);
      after_rise();
      check("r0_wE3",      wE3,      0);
      check("r0_A3",       A3,       0);
      check("r0_wD3",      wD3,      32'h7FFFF);
      check("r0_last_gnt", last_gnt, 1);
      v1 = 1'b0;

      // Same-address conflict: a0=a1=5, d0=1, d1=2. Requester 0 wins first.
      @(negedge clk);
      v0 = 1'b1; a0 = 3'd5; d0 = 19'd1;
      v1 = 1'b1; a1 = 3'd5; d1 = 19'd2;
      #1;
      check("cf_rdy0", rdy0, 1);
      check("cf_rdy1", rdy1, 0);
      after_rise();
      check("cf_wE3_a", wE3,       1);
      check("cf_A3_a",  A3,        5);
      check("cf_wD3_a", wD3,       1);
      check("cf_stall", stall_cnt, 1);
      @(negedge clk);
      v0 = 1'b0;
      #1;
      check("cf_rdy1_b", rdy1, 1);
      after_rise();
      check("cf_wE3_b",  wE3,       1);
      check("cf_A3_b",   A3,        5);
      check("cf_wD3_b",  wD3,       2);
      check("cf_last_b", last_gnt,  1);
      check("cf_stall2", stall_cnt, 1);
      @(negedge clk);
      v1 = 1'b0;

      // Continuous contention: both valid for 10 cycles.
      @(negedge clk);
      v0 = 1'b1; a0 = 3'd1; d0 = 19'h00011;
      v1 = 1'b1; a1 = 3'd2; d1 = 19'h00022;
      exp_stall = 8'd1;
      for (int i = 0; i < 10; i++) begin
`ifdef WB_ROUND_ROBIN_EN
         exp_g1 = (i % 2) == 1;
`else
         exp_g1 = (i % 5) == 4;
`endif
         #1;
         check($sformatf("cc_rdy0_%0d", i), rdy0, !exp_g1);
         check($sformatf("cc_rdy1_%0d", i), rdy1, exp_g1);
         after_rise();
         exp_stall = exp_stall + 8'd1;
         check($sformatf("cc_A3_%0d", i),    A3,        exp_g1 ? 2 : 1);
         check($sformatf("cc_last_%0d", i),  last_gnt,  exp_g1);
         check($sformatf("cc_stall_%0d", i), stall_cnt, exp_stall);
         @(negedge clk);
      end
      v0 = 1'b0; v1 = 1'b0;

      // Reset with a write pending in the output stage.
      @(negedge clk);
      v0 = 1'b1; a0 = 3'd6; d0 = 19'h05A5A;
      after_rise();
      check("pr_wE3_pending", wE3, 1);
      check("pr_A3_pending",  A3,  6);
      #1;
      rst = 1'b1;
      #1;
      check("pr_wE3",      wE3,       0);
      check("pr_A3",       A3,        0);
      check("pr_wD3",      wD3,       0);
      check("pr_stall",    stall_cnt, 0);
      check("pr_last_gnt", last_gnt,  1);
      check("pr_rdy0",     rdy0,      0);
      v0 = 1'b0;
      after_rise();
      check("pr_no_write", wE3, 0);
      @(negedge clk);
      rst = 1'b0;

      // Saturation: 300 cycles of contention; grants resume on the first edge.
      v0 = 1'b1; a0 = 3'd7; d0 = 19'h00077;
      v1 = 1'b1; a1 = 3'd4; d1 = 19'h00044;
      after_rise();
      check("sat_first_wE3",   wE3,       1);
      check("sat_first_A3",    A3,        7);
      check("sat_first_stall", stall_cnt, 1);
      for (int i = 2; i <= 300; i++) begin
         after_rise();
         if (i == 254) check("sat_254", stall_cnt, 254);
         if (i == 255) check("sat_255", stall_cnt, 255);
      end
      check("sat_300", stall_cnt, 255);
      v0 = 1'b0; v1 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
